// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges the single-cycle ALU path with a
// buffered memory/load path and tracks outstanding loads for hazard logic.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  output logic        alu_stall,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_wd,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] pending,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        rf_we
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    fifo_rd [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic        fifo_empty;
  logic        alu_acc;
  logic        alu_wr;
  logic        push;
  logic        pop;
  logic        blocked;
  logic        stall_next;
  logic [4:0]  head_rd;
  logic [31:0] head_wd;
  logic [31:0] pending_next;

  assign fifo_empty = (count == '0);
  assign mem_ready  = (count != CW'(DEPTH));
  assign alu_acc    = alu_valid && !alu_stall;
  // An rd=0 ALU result is dropped and leaves the port free for the FIFO.
  assign alu_wr     = alu_acc && (alu_rd != 5'd0);
  assign push       = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign pop        = !alu_wr && !fifo_empty;
  assign blocked    = alu_wr && !fifo_empty;
  assign stall_next = blocked && (starve_cnt == SW'(STARVE_MAX - 1));
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_wd    = fifo_wd[rd_ptr];

  // Set beats clear when a new load to r issues as the old one retires.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr] <= mem_rd;
      fifo_wd[wr_ptr] <= mem_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      pending    <= '0;
      rf_we      <= 1'b0;
      rf_a3      <= 5'd0;
      rf_wd3     <= 32'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (stall_next)
        starve_cnt <= '0;
      else if (blocked)
        starve_cnt <= starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
      alu_stall <= stall_next;

      pending <= pending_next;

      if (alu_wr) begin
        rf_we  <= 1'b1;
        rf_a3  <= alu_rd;
        rf_wd3 <= alu_wd;
      end else if (pop) begin
        rf_we  <= 1'b1;
        rf_a3  <= head_rd;
        rf_wd3 <= head_wd;
      end else begin
        rf_we  <= 1'b0;
      end
    end
  end

endmodule
